// File: rtl/imm_encoder_pkg.sv
// Shared types and constants for the RV32I immediate encoder.
// Holds the format codes, the NOP word and the signed offset limits.
package imm_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4
    } fmt_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] BOFF_MIN  = -32'sd4096;
    localparam logic signed [31:0] BOFF_MAX  = 32'sd4094;
    localparam logic signed [31:0] JOFF_MIN  = -32'sd1048576;
    localparam logic signed [31:0] JOFF_MAX  = 32'sd1048574;

    function automatic logic in_range(input logic [31:0] val,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return ($signed(val) >= lo) && ($signed(val) <= hi);
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational range/alignment check and bit scatter of one RV32I word.
// Any encoding error yields the canonical NOP with err set.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] off,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    output logic [31:0] instr,
    output logic        err
);

    // Per-format legality test followed by field placement.
    always_comb begin
        instr = NOP_INSTR;
        err   = 1'b1;
        case (fmt)
            FMT_I: begin
                if (in_range(off, IMM12_MIN, IMM12_MAX)) begin
                    instr = {off[11:0], rs1, funct3, rd, opcode};
                    err   = 1'b0;
                end else begin
                    instr = NOP_INSTR;
                    err   = 1'b1;
                end
            end
            FMT_S: begin
                if (in_range(off, IMM12_MIN, IMM12_MAX)) begin
                    instr = {off[11:5], rs2, rs1, funct3, off[4:0], opcode};
                    err   = 1'b0;
                end else begin
                    instr = NOP_INSTR;
                    err   = 1'b1;
                end
            end
            FMT_B: begin
                if (in_range(off, BOFF_MIN, BOFF_MAX) && (off[0] == 1'b0)) begin
                    instr = {off[12], off[10:5], rs2, rs1, funct3, off[4:1], off[11], opcode};
                    err   = 1'b0;
                end else begin
                    instr = NOP_INSTR;
                    err   = 1'b1;
                end
            end
            FMT_U: begin
                if (off[11:0] == 12'h000) begin
                    instr = {off[31:12], rd, opcode};
                    err   = 1'b0;
                end else begin
                    instr = NOP_INSTR;
                    err   = 1'b1;
                end
            end
            FMT_J: begin
                if (in_range(off, JOFF_MIN, JOFF_MAX) && (off[0] == 1'b0)) begin
                    instr = {off[20], off[10:1], off[11], off[19:12], rd, opcode};
                    err   = 1'b0;
                end else begin
                    instr = NOP_INSTR;
                    err   = 1'b1;
                end
            end
            default: begin
                instr = NOP_INSTR;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage RV32I instruction packer: stage 1 captures fields and forms the
// PC-relative offset, stage 2 checks/packs and drives the registered output.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter logic [31:0] PC_BASE  = 32'h0000_0000,
    parameter int          ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_fmt,
    input  logic [6:0]          in_opcode,
    input  logic [4:0]          in_rd,
    input  logic [4:0]          in_rs1,
    input  logic [4:0]          in_rs2,
    input  logic [2:0]          in_funct3,
    input  logic [31:0]         in_imm,
    input  logic                pc_load,
    input  logic [31:0]         pc_load_val,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [31:0]         out_addr,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_count
);

    logic [31:0]         pc_r;
    logic                s1_valid_r;
    logic [2:0]          s1_fmt_r;
    logic [31:0]         s1_off_r;
    logic [6:0]          s1_opcode_r;
    logic [4:0]          s1_rd_r;
    logic [4:0]          s1_rs1_r;
    logic [4:0]          s1_rs2_r;
    logic [2:0]          s1_funct3_r;
    logic [31:0]         s1_addr_r;
    logic                s2_valid_r;
    logic [31:0]         out_instr_r;
    logic [31:0]         out_addr_r;
    logic                out_err_r;
    logic [ERRCNT_W-1:0] err_count_r;

    logic        s1_adv_s;
    logic        in_ready_s;
    logic        accept_s;
    logic [31:0] off_s;
    logic [31:0] pack_instr_s;
    logic        pack_err_s;

    assign s1_adv_s   = !s2_valid_r || out_ready;
    assign in_ready_s = !pc_load && (!s1_valid_r || s1_adv_s);
    assign accept_s   = in_valid && in_ready_s;

    // Branch/jump targets become offsets relative to the word's own address.
    always_comb begin
        off_s = in_imm;
        if ((in_fmt == FMT_B) || (in_fmt == FMT_J)) begin
            off_s = in_imm - pc_r;
        end else begin
            off_s = in_imm;
        end
    end

    // Instruction-address counter: explicit load wins, else advance per accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= PC_BASE;
        end else if (pc_load) begin
            pc_r <= pc_load_val;
        end else if (accept_s) begin
            pc_r <= pc_r + 32'd4;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Stage 1 capture register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_fmt_r    <= 3'd0;
            s1_off_r    <= 32'd0;
            s1_opcode_r <= 7'd0;
            s1_rd_r     <= 5'd0;
            s1_rs1_r    <= 5'd0;
            s1_rs2_r    <= 5'd0;
            s1_funct3_r <= 3'd0;
            s1_addr_r   <= 32'd0;
        end else if (accept_s) begin
            s1_valid_r  <= 1'b1;
            s1_fmt_r    <= in_fmt;
            s1_off_r    <= off_s;
            s1_opcode_r <= in_opcode;
            s1_rd_r     <= in_rd;
            s1_rs1_r    <= in_rs1;
            s1_rs2_r    <= in_rs2;
            s1_funct3_r <= in_funct3;
            s1_addr_r   <= pc_r;
        end else if (s1_adv_s) begin
            s1_valid_r  <= 1'b0;
        end else begin
            s1_valid_r  <= s1_valid_r;
        end
    end

    imm_pack u_pack (
        .fmt    (s1_fmt_r),
        .off    (s1_off_r),
        .opcode (s1_opcode_r),
        .rd     (s1_rd_r),
        .rs1    (s1_rs1_r),
        .rs2    (s1_rs2_r),
        .funct3 (s1_funct3_r),
        .instr  (pack_instr_s),
        .err    (pack_err_s)
    );

    // Stage 2 output register; data is frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r  <= 1'b0;
            out_instr_r <= 32'd0;
            out_addr_r  <= 32'd0;
            out_err_r   <= 1'b0;
            err_count_r <= {ERRCNT_W{1'b0}};
        end else if (s1_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_instr_r <= pack_instr_s;
                out_addr_r  <= s1_addr_r;
                out_err_r   <= pack_err_s;
                if (pack_err_s && (err_count_r != {ERRCNT_W{1'b1}})) begin
                    err_count_r <= err_count_r + ERRCNT_W'(1);
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_r;
    assign out_instr = out_instr_r;
    assign out_addr  = out_addr_r;
    assign out_err   = out_err_r;
    assign err_count = err_count_r;

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
Inverse of the immediate generator. Accepts decoded instruction fields plus a 32-bit immediate or absolute branch/jump target, and packs them into an RV32I instruction word.
- B/J formats: the block converts the target to a PC-relative offset using an internal instruction-address counter.
- Sits between the test/boot loader and instruction memory, feeding a write port through a valid/ready stream.
- 2-stage pipeline with range/alignment checking.

Parameters:
PC_BASE, 32'h0000_0000, address of the first emitted instruction after reset.
ERRCNT_W, 8, width of the saturating error counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
in_valid  in  1  input field bundle valid.
in_ready  out  1  block can accept the bundle.
in_fmt  in  3  0=I, 1=S, 2=B, 3=U, 4=J, 5-7 illegal.
in_opcode  in  7  opcode, copied to instr[6:0].
in_rd  in  5  rd, for I/U/J.
in_rs1  in  5  rs1, for I/S/B.
in_rs2  in  5  rs2, for S/B.
in_funct3  in  3  funct3, for I/S/B.
in_imm  in  32  immediate (I/S/U) or absolute target address (B/J).
pc_load  in  1  load instruction-address counter.
pc_load_val  in  32  new counter value.
out_valid  out  1  packed word valid.
out_ready  in  1  downstream accepts word.
out_instr  out  32  packed instruction.
out_addr  out  32  address of out_instr.
out_err  out  1  word was replaced by NOP due to an encoding error.
err_count  out  ERRCNT_W  saturating count of errored words.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - pc <= PC_BASE; both stage valids <= 0.
  - out_valid=0, out_instr=0, out_addr=0, out_err=0, err_count=0.
  - Reset mid-operation discards in-flight words.
- Handshake:
  - Transfer on valid&ready at a rising edge.
  - in_ready = !pc_load && (!s1_valid || s1_adv); s1_adv = !s2_valid || out_ready.
  - in_ready is combinational from out_ready; out_valid and outputs come from registers.
  - out_valid holds, with stable data, until out_ready.
- Stage 1 (on accept):
  - Capture fields; s1_addr <= pc; pc <= pc + 4, wrapping modulo 2^32.
  - B/J: off = in_imm - pc (32-bit two's complement).
  - I/S/U: off = in_imm.
- Stage 2 (error check; any error -> NOP):
  - I/S: error if off is not in [-2048, 2047].
  - B: error if off is not in [-4096, 4094] or off[0]=1.
  - J: error if off is not in [-1048576, 1048574] or off[0]=1.
  - U: error if off[11:0] != 0.
  - fmt 5-7: always error.
  - On error: out_instr = 32'h0000_0013 (addi x0,x0,0), out_err=1, err_count += 1, saturating at all-ones.
- Stage 2 (packing when error-free):
  - I: {off[11:0], rs1, f3, rd, op}.
  - S: {off[11:5], rs2, rs1, f3, off[4:0], op}.
  - B: {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], op}.
  - U: {off[31:12], rd, op}.
  - J: {off[20], off[10:1], off[11], off[19:12], rd, op}.
  - out_addr = s1_addr.
- Latency: exactly 2 cycles from accept to out_valid with no stall. Throughput is 1 word per cycle.
- Backpressure: pipeline holds 2 words. With out_ready=0, at most 2 accepts occur, then in_ready=0. Order is preserved, with no loss or duplication.
- pc_load: pc <= pc_load_val; in_ready=0 that cycle. In-flight words keep their captured addresses.
- Error words still consume an address (pc advances).

Decomposition:
- Shared package: fmt enum (FMT_I, FMT_S, FMT_B, FMT_U, FMT_J); NOP_INSTR = 32'h0000_0013; range-limit localparams.
- Sub-module imm_pack: combinational error check plus bit scatter (fmt, off, fields -> instr, err). The pipeline, pc and handshake stay in imm_encoder.

Test Plan:
- Reset, I, opcode 0x13, rd=1, rs1=0, imm=5 -> after 2 cycles out_instr=0x00500093, out_addr=0, out_err=0.
- B at pc=4, opcode 0x63, rs1=rs2=0, f3=0, target=0 -> out_instr=0xFE000EE3, out_addr=4. J at pc=8, rd=1, opcode 0x6F, target=0x10 -> 0x008000EF.
- U, opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7. Same with imm=0x12345001 -> 0x00000013, out_err=1, err_count=1.
- Range/alignment errors:
  - I with imm=2048 -> NOP, err.
  - B with odd target -> NOP, err.
  - J with offset +1048574 -> valid encoding.
  - Assert that pc still advances by 4 on each errored word.
- Backpressure: out_ready=0, 3 back-to-back bundles -> 2 accepted, in_ready=0. Release -> words at addrs 0, 4, 8 in order, one per cycle.
- Pipeline control:
  - pc_load 0x100 with in_valid=1 -> no accept that cycle; next accepted word has out_addr=0x100.
  - rst mid-stream -> out_valid=0 next cycle; next word has addr=PC_BASE.
